// File: rtl/parity_tx_ctrl_if.sv
// Byte handshake between a requester and parity_tx_ctrl.
// err_inject exists only when PARITY_ERR_INJECT_EN is defined.
interface parity_tx_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       even_odd;
    logic       in_ready;
`ifdef PARITY_ERR_INJECT_EN
    logic       err_inject;

    modport master (output in_valid, in_data, even_odd, err_inject, input in_ready);
    modport slave  (input in_valid, in_data, even_odd, err_inject, output in_ready);
`else
    modport master (output in_valid, in_data, even_odd, input in_ready);
    modport slave  (input in_valid, in_data, even_odd, output in_ready);
`endif
endinterface

// File: rtl/parity_tx_ctrl.sv
// Serial framer: start(0), d0..d7 LSB first, parity, stop(1), each held BIT_CYCLES clocks.
// Optional PARITY_ERR_INJECT_EN adds err_inject to flip the parity bit of one frame.
module parity_tx_ctrl #(
    parameter int BIT_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    parity_tx_ctrl_if.slave         in_if,
    output logic                    tx_out,
    output logic                    busy,
    output logic                    done,
    output logic                    parity_out
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] LAST_CYCLE = 8'(BIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       parity_q, parity_d;
    logic       tx_out_q, tx_out_d;
    logic       done_q, done_d;

    logic       inj;
    logic       parity_calc;
    logic       bit_end;

`ifdef PARITY_ERR_INJECT_EN
    assign inj = in_if.err_inject;
`else
    assign inj = 1'b0;
`endif

    // XOR-reduce gives even parity; odd mode and error injection each flip it.
    assign parity_calc = (^in_if.in_data) ^ ~in_if.even_odd ^ inj;
    assign bit_end     = (cnt_q == LAST_CYCLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        tx_out_d = 1'b1;

        if (state_q == IDLE) begin
            cnt_d = 8'd0;
            idx_d = 3'd0;
            if (in_if.in_valid) begin
                state_d  = START;
                data_d   = in_if.in_data;
                parity_d = parity_calc;
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
            unique case (state_q)
                START: begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
                DATA: begin
                    if (idx_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                PARITY: state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        // Register the level of the state being entered so tx_out lines up with state_q.
        unique case (state_d)
            IDLE:    tx_out_d = 1'b1;
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = data_d[idx_d];
            PARITY:  tx_out_d = parity_d;
            STOP:    tx_out_d = 1'b1;
            default: tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= 3'd0;
            data_q   <= 8'd0;
            parity_q <= 1'b0;
            tx_out_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            tx_out_q <= tx_out_d;
            done_q   <= done_d;
        end
    end

    assign in_if.in_ready = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign tx_out         = tx_out_q;
    assign parity_out     = parity_q;
endmodule
